// File: rtl/seg8_pwl_pkg.sv
// Shared FP16 constants, operand helpers and the 2^f chord-fit reset tables
// for the 8-segment piecewise-linear evaluator.
package seg8_pwl_pkg;

    localparam int FP16_W       = 16;
    localparam int FP16_EXP_W   = 5;
    localparam int FP16_MAN_W   = 10;
    localparam int FP16_BIAS    = 15;
    localparam int FP16_EXP_MAX = 30;
    localparam logic [FP16_W-1:0] FP16_MAXF = 16'h7BFF;
    localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

    localparam int SEG_N = 8;

    typedef enum logic {
        COEF_SLOPE     = 1'b0,
        COEF_INTERCEPT = 1'b1
    } coef_sel_e;

    typedef struct packed {
        logic                  zero;
        logic [FP16_EXP_W-1:0] expo;
        logic [FP16_MAN_W-1:0] man;
    } fp16_op_t;

    // Chord fit of 2^f over [k/8, (k+1)/8), each value truncated to FP16.
    localparam logic [FP16_W-1:0] PWL_EXP2_SLOPE [SEG_N] = '{
        16'h39CA, 16'h3A51, 16'h3AE3, 16'h3B83,
        16'h3C18, 16'h3C77, 16'h3CDE, 16'h3D4F
    };
    localparam logic [FP16_W-1:0] PWL_EXP2_INTERCEPT [SEG_N] = '{
        16'h3C00, 16'h3BEF, 16'h3BCA, 16'h3B8E,
        16'h3B37, 16'h3AC1, 16'h3A25, 16'h3960
    };

    // Sign is dropped, subnormals flush to zero, Inf/NaN clamp to the largest finite value.
    function automatic fp16_op_t fp16_unpack(input logic [FP16_W-1:0] x);
        fp16_op_t op;
        op.zero = 1'b0;
        op.expo = x[14:10];
        op.man  = x[9:0];
        if (x[14:10] == 5'd0) begin
            op.zero = 1'b1;
            op.expo = '0;
            op.man  = '0;
        end else if (x[14:10] == 5'd31) begin
            op.expo = 5'(FP16_EXP_MAX);
            op.man  = '1;
        end
        return op;
    endfunction

    function automatic logic [FP16_W-1:0] fp16_pack(input logic signed [7:0] e,
                                                     input logic [FP16_MAN_W-1:0] man);
        logic [FP16_W-1:0] r;
        if (e > 8'sd30) begin
            r = FP16_MAXF;
        end else if (e < 8'sd1) begin
            r = FP16_ZERO;
        end else begin
            r = {1'b0, e[4:0], man};
        end
        return r;
    endfunction

endpackage

// File: rtl/seg8_pwl_eval_mul.sv
// Combinational positive-only FP16 multiply, truncating toward zero with
// saturation above the top exponent and flush below the bottom one.
module fp16_pos_mul
    import seg8_pwl_pkg::*;
(
    input  logic [FP16_W-1:0] a_i,
    input  logic [FP16_W-1:0] b_i,
    output logic [FP16_W-1:0] p_o
);

    fp16_op_t               a_op;
    fp16_op_t               b_op;
    logic [21:0]            prod;
    logic signed [7:0]      e_raw;
    logic signed [7:0]      e_norm;
    logic [FP16_MAN_W-1:0]  man;
    logic                   mul_unused;

    always_comb begin
        a_op   = fp16_unpack(a_i);
        b_op   = fp16_unpack(b_i);
        prod   = 22'({1'b1, a_op.man}) * 22'({1'b1, b_op.man});
        e_raw  = $signed({3'b000, a_op.expo}) + $signed({3'b000, b_op.expo})
                 - 8'(FP16_BIAS);
        // The product of two [1,2) significands lies in [1,4); bit 21 flags the [2,4) half.
        e_norm = e_raw + $signed({7'd0, prod[21]});
        man    = prod[21] ? prod[20:11] : prod[19:10];
        p_o    = fp16_pack(e_norm, man);
        if (a_op.zero || b_op.zero) begin
            p_o = FP16_ZERO;
        end
    end

    // Low product bits fall below the truncated mantissa.
    assign mul_unused = ^prod[9:0];

endmodule

// File: rtl/seg8_pwl_eval.sv
// 3-stage piecewise-linear evaluator: y = intercept[seg] + slope[seg]*f in
// positive-only FP16, one sample per cycle, with a runtime-writable coefficient table.
module seg8_pwl_eval
    import seg8_pwl_pkg::*;
#(
    parameter int DW = 16,
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          valid_i,
    input  logic [2:0]    seg_i,
    input  logic [DW-1:0] f_i,
    input  logic [TW-1:0] tag_i,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [DW-1:0] cfg_wdata,
    output logic [DW-1:0] y_o,
    output logic [TW-1:0] tag_o,
    output logic          valid_o
);

    localparam int COEF_N = 2 * SEG_N;

    // Entries 0..7 are slopes, 8..15 intercepts, matching the cfg_addr layout.
    logic [COEF_N-1:0][DW-1:0] coef_tbl;

    for (genvar gi = 0; gi < COEF_N; gi++) begin : g_coef
        localparam logic [DW-1:0] RST_VAL = (gi < SEG_N) ? PWL_EXP2_SLOPE[gi % SEG_N]
                                                          : PWL_EXP2_INTERCEPT[gi % SEG_N];
        logic [DW-1:0] coef_q;
        logic [DW-1:0] coef_d;

        always_comb begin
            coef_d = coef_q;
            if (cfg_we && (cfg_addr == 4'(gi))) begin
                coef_d = cfg_wdata;
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                coef_q <= RST_VAL;
            end else begin
                coef_q <= coef_d;
            end
        end

        assign coef_tbl[gi] = coef_q;
    end

    logic [3:0] slope_idx;
    logic [3:0] icpt_idx;

    assign slope_idx = {1'(COEF_SLOPE), seg_i};
    assign icpt_idx  = {1'(COEF_INTERCEPT), seg_i};

    // S1: operand capture and registered table lookup (a same-edge write is not yet visible).
    logic          v1_q;
    logic [DW-1:0] f1_q;
    logic [DW-1:0] slope1_q;
    logic [DW-1:0] icpt1_q;
    logic [TW-1:0] tag1_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q     <= 1'b0;
            f1_q     <= '0;
            slope1_q <= '0;
            icpt1_q  <= '0;
            tag1_q   <= '0;
        end else begin
            v1_q <= valid_i;
            if (valid_i) begin
                f1_q     <= f_i;
                slope1_q <= coef_tbl[slope_idx];
                icpt1_q  <= coef_tbl[icpt_idx];
                tag1_q   <= tag_i;
            end
        end
    end

    // S2: product.
    logic          v2_q;
    logic [DW-1:0] p2_d;
    logic [DW-1:0] p2_q;
    logic [DW-1:0] icpt2_q;
    logic [TW-1:0] tag2_q;

    fp16_pos_mul u_mul (
        .a_i (slope1_q),
        .b_i (f1_q),
        .p_o (p2_d)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2_q    <= 1'b0;
            p2_q    <= '0;
            icpt2_q <= '0;
            tag2_q  <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                p2_q    <= p2_d;
                icpt2_q <= icpt1_q;
                tag2_q  <= tag1_q;
            end
        end
    end

    // S3: positive-only add; both operands are non-negative so no left normalisation is needed.
    fp16_op_t              p_op;
    fp16_op_t              c_op;
    fp16_op_t              big_op;
    fp16_op_t              small_op;
    logic [4:0]            shamt;
    logic [10:0]           small_sig;
    logic [11:0]           sum;
    logic signed [7:0]     e_sum;
    logic [FP16_MAN_W-1:0] man_sum;
    logic [DW-1:0]         y3_d;

    always_comb begin
        p_op = fp16_unpack(p2_q);
        c_op = fp16_unpack(icpt2_q);
        if (p_op.expo >= c_op.expo) begin
            big_op   = p_op;
            small_op = c_op;
        end else begin
            big_op   = c_op;
            small_op = p_op;
        end
        shamt     = big_op.expo - small_op.expo;
        small_sig = {1'b1, small_op.man} >> shamt;
        if (small_op.zero || (shamt >= 5'd12)) begin
            small_sig = '0;
        end
        sum     = {1'b0, 1'b1, big_op.man} + {1'b0, small_sig};
        e_sum   = $signed({3'b000, big_op.expo}) + $signed({7'd0, sum[11]});
        man_sum = sum[11] ? sum[10:1] : sum[9:0];
        y3_d    = fp16_pack(e_sum, man_sum);
        // A zero big operand implies both are zero.
        if (big_op.zero) begin
            y3_d = FP16_ZERO;
        end
    end

    logic          valid_q;
    logic [DW-1:0] y_q;
    logic [TW-1:0] tag_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            y_q     <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= v2_q;
            if (v2_q) begin
                y_q   <= y3_d;
                tag_q <= tag2_q;
            end
        end
    end

    assign y_o     = y_q;
    assign tag_o   = tag_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_seg8_pwl_eval.sv
// Scoreboard bench for seg8_pwl_eval: expected results are queued with their
// due cycle when driven and compared as valid_o pulses arrive.
module tb_seg8_pwl_eval;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        valid_i = 1'b0;
    logic [2:0]  seg_i = '0;
    logic [15:0] f_i = '0;
    logic [7:0]  tag_i = '0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    logic [15:0] y_o;
    logic [7:0]  tag_o;
    logic        valid_o;

    seg8_pwl_eval #(.DW(16), .TW(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .valid_i   (valid_i),
        .seg_i     (seg_i),
        .f_i       (f_i),
        .tag_i     (tag_i),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .y_o       (y_o),
        .tag_o     (tag_o),
        .valid_o   (valid_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] y;
        logic [7:0]  tag;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   n_valid = 0;

    logic [15:0] sh_slope [8];
    logic [15:0] sh_icpt  [8];

    task automatic load_defaults();
        sh_slope = '{16'h39CA, 16'h3A51, 16'h3AE3, 16'h3B83,
                     16'h3C18, 16'h3C77, 16'h3CDE, 16'h3D4F};
        sh_icpt  = '{16'h3C00, 16'h3BEF, 16'h3BCA, 16'h3B8E,
                     16'h3B37, 16'h3AC1, 16'h3A25, 16'h3960};
    endtask

    // Reference FP16 arithmetic on plain integers.
    function automatic logic [15:0] m_clean(input logic [15:0] x);
        logic [15:0] v;
        v = x & 16'h7FFF;
        if (v[14:10] == 5'd0) return 16'h0000;
        if (v[14:10] == 5'd31) return 16'h7BFF;
        return v;
    endfunction

    function automatic logic [15:0] m_range(input int e, input int man);
        logic [15:0] r;
        if (e > 30) return 16'h7BFF;
        if (e < 1) return 16'h0000;
        r = 16'((e << 10) | (man & 1023));
        return r;
    endfunction

    function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] ca;
        logic [15:0] cb;
        int prod;
        int e;
        ca = m_clean(a);
        cb = m_clean(b);
        if (ca == 16'h0 || cb == 16'h0) return 16'h0000;
        prod = (1024 + int'(ca[9:0])) * (1024 + int'(cb[9:0]));
        e = int'(ca[14:10]) + int'(cb[14:10]) - 15;
        if (prod >= (1 << 21)) begin
            prod = prod >> 1;
            e++;
        end
        return m_range(e, (prod >> 10) - 1024);
    endfunction

    function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] ca;
        logic [15:0] cb;
        logic [15:0] t;
        int d;
        int sa;
        int sb;
        int s;
        int e;
        ca = m_clean(a);
        cb = m_clean(b);
        if (ca == 16'h0) return cb;
        if (cb == 16'h0) return ca;
        if (ca[14:10] < cb[14:10]) begin
            t = ca; ca = cb; cb = t;
        end
        d  = int'(ca[14:10]) - int'(cb[14:10]);
        sa = 1024 + int'(ca[9:0]);
        sb = (d >= 12) ? 0 : ((1024 + int'(cb[9:0])) >> d);
        s  = sa + sb;
        e  = int'(ca[14:10]);
        if (s >= 2048) begin
            s = s >> 1;
            e++;
        end
        return m_range(e, s - 1024);
    endfunction

    function automatic logic [15:0] model_y(input logic [2:0] seg, input logic [15:0] f);
        return m_add(m_mul(sh_slope[seg], f), sh_icpt[seg]);
    endfunction

    // Output monitor: every valid_o pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid_o === 1'b1) begin
                n_valid++;
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_valid: y_o=%h tag_o=%h cyc=%0d, required no output",
                             y_o, tag_o, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (y_o !== e.y || tag_o !== e.tag || cyc !== e.due) begin
                        n_fail++;
                        $display("FAIL result: y_o=%h tag_o=%h cyc=%0d, required y=%h tag=%h cyc=%0d",
                                 y_o, tag_o, cyc, e.y, e.tag, e.due);
                    end else begin
                        $display("ok   result: y_o=%h tag_o=%h cyc=%0d", y_o, tag_o, cyc);
                    end
                end
            end
        end
    end

    task automatic send(input logic [2:0] seg, input logic [15:0] f, input logic [7:0] tag,
                        input logic [15:0] exp_y);
        exp_t e;
        valid_i = 1'b1;
        seg_i   = seg;
        f_i     = f;
        tag_i   = tag;
        e.y   = exp_y;
        e.tag = tag;
        e.due = cyc + 3;
        sb_q.push_back(e);
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
        if (addr[3]) sh_icpt[addr[2:0]] = d;
        else         sh_slope[addr[2:0]] = d;
        $display("cfg  write: addr=%h data=%h", addr, d);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        int nv0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (y_o !== 16'h0000) begin
            n_fail++; $display("FAIL reset_y: y_o=%h, required 0000", y_o);
        end
        n_vec++;
        if (tag_o !== 8'h00) begin
            n_fail++; $display("FAIL reset_tag: tag_o=%h, required 00", tag_o);
        end
        n_vec++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: valid_o=%b, required 0", valid_o);
        end
        rstn = 1'b1;
        load_defaults();
        @(negedge clk);
        nv0 = n_valid;
        send(3'd0, 16'h0000, 8'h5A, 16'h3C00);
        drain("reset_default");
        repeat (4) @(negedge clk);
        n_vec++;
        if (n_valid - nv0 != 1) begin
            n_fail++;
            $display("FAIL reset_pulse_width: valid_o pulses=%0d, required 1", n_valid - nv0);
        end
    endtask

    task automatic test_cfg_eval();
        cfg_write(4'h2, 16'h3C00);
        cfg_write(4'hA, 16'h3C00);
        send(3'd2, 16'h3800, 8'h21, 16'h3E00);
        drain("cfg_eval");
        repeat (3) @(negedge clk);
        n_vec++;
        if (y_o !== 16'h3E00 || tag_o !== 8'h21 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_idle: y_o=%h tag_o=%h valid_o=%b, required 3e00 21 0",
                     y_o, tag_o, valid_o);
        end
    endtask

    task automatic test_zero_intercept();
        cfg_write(4'h5, 16'h4000);
        cfg_write(4'hD, 16'h0000);
        send(3'd5, 16'h3400, 8'h33, 16'h3800);
        send(3'd5, 16'h0000, 8'h34, 16'h0000);
        drain("zero_intercept");
    endtask

    task automatic test_streaming();
        logic [15:0] f;
        for (int k = 0; k < 8; k++) begin
            f = 16'($urandom_range(16'h3BFF, 16'h0000));
            send(3'(k), f, 8'(8'h80 + k), model_y(3'(k), f));
            if (k == 3) @(negedge clk);
        end
        drain("streaming");
    endtask

    task automatic test_back_to_back_collision();
        cfg_we    = 1'b1;
        cfg_addr  = 4'h1;
        cfg_wdata = 16'h4000;
        send(3'd1, 16'h3800, 8'h41, 16'h3D8B);
        cfg_we = 1'b0;
        sh_slope[1] = 16'h4000;
        send(3'd1, 16'h3800, 8'h42, 16'h3FF7);
        drain("collision");
    endtask

    task automatic test_reset_midstream();
        valid_i = 1'b1; seg_i = 3'd2; f_i = 16'h3800; tag_i = 8'h71;
        @(negedge clk);
        seg_i = 3'd3; tag_i = 8'h72;
        @(negedge clk);
        seg_i = 3'd4; tag_i = 8'h73;
        rstn = 1'b0;
        load_defaults();
        #1;
        n_vec++;
        if (y_o !== 16'h0000 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: y_o=%h valid_o=%b, required 0000 0", y_o, valid_o);
        end
        @(negedge clk);
        n_vec++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL midreset_valid: valid_o=%b, required 0", valid_o);
        end
        @(negedge clk);
        valid_i = 1'b0;
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        send(3'd2, 16'h3800, 8'h77, 16'h3D9D);
        drain("midreset_default");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        load_defaults();
        test_reset();
        test_cfg_eval();
        test_zero_intercept();
        test_streaming();
        test_back_to_back_collision();
        test_reset_midstream();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
